// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Unsigned restoring divider, one quotient bit per clock, MSB
//             first. A zero divisor completes in a single cycle with a
//             saturated quotient and the div_by_zero flag set.
//  Ports    : clk          - sole clock, rising edge
//             rst_n        - asynchronous active-low reset
//             start        - request, accepted only in IDLE or DONE
//             dividend     - numerator, latched with an accepted start
//             divisor      - denominator, latched with an accepted start
//             busy         - high while the division iterates (CALC)
//             done         - one-cycle result-valid pulse (DONE)
//             quotient     - registered quotient
//             remainder    - registered remainder
//             div_by_zero  - registered flag for the last completed request
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int c_cnt_w = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_count;
    // Holds the not-yet-consumed dividend bits at the top and accumulates
    // quotient bits at the bottom; after DIVIDEND_W shifts it is the quotient.
    logic [DIVIDEND_W-1:0] r_work;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;

    // The shifted partial remainder needs DIVISOR_W+1 bits: the stored value
    // is always below the divisor, so doubling it plus one cannot exceed
    // that width.
    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;
    logic [DIVISOR_W-1:0]  w_rem_next;
    logic [DIVIDEND_W-1:0] w_work_next;

    assign w_shift     = {r_rem, r_work[DIVIDEND_W-1]};
    assign w_ge        = (w_shift >= {1'b0, r_divisor});
    // The difference is smaller than the divisor, so the low bits carry it
    // exactly and the extra top bit can be dropped.
    assign w_diff      = w_shift[DIVISOR_W-1:0] - r_divisor;
    assign w_rem_next  = w_ge ? w_diff : w_shift[DIVISOR_W-1:0];
    assign w_work_next = {r_work[DIVIDEND_W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_work        <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Degenerate request: answer immediately.
                            r_state       <= DONE;
                            r_quotient    <= '1;
                            r_remainder   <= '0;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_state   <= CALC;
                            r_work    <= dividend;
                            r_divisor <= divisor;
                            r_rem     <= '0;
                            r_count   <= '0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_work  <= w_work_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_last_step) begin
                        r_state       <= DONE;
                        r_quotient    <= w_work_next;
                        r_remainder   <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == CALC);
    assign done        = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Directed self-checking bench for seq_divider (8/4 default),
//             followed by a sweep of every dividend/divisor pair.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    // Result the outputs must keep showing while a new division iterates.
    logic [7:0] hold_q = '0;
    logic [3:0] hold_r = '0;
    logic       hold_z = 1'b0;

    seq_divider #(
        .DIVIDEND_W (8),
        .DIVISOR_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request now (so it is accepted at the next edge), then follow
    // it to completion. Returns 1 ns after the completing edge, i.e. inside
    // the done cycle, so a following call exercises back-to-back starts.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic ez,
                           input bit full);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        // Scramble the operand inputs to prove they were latched.
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        if (b != 4'd0) begin
            for (int i = 0; i < 8; i++) begin
                if (full) begin
                    check({tag, "_busy"}, busy, 1'b1);
                    check({tag, "_nodone"}, done, 1'b0);
                    check({tag, "_holdq"}, quotient, hold_q);
                    check({tag, "_holdr"}, remainder, hold_r);
                    check({tag, "_holdz"}, div_by_zero, hold_z);
                end
                tick();
            end
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        hold_q = eq;
        hold_r = er;
        hold_z = ez;
    endtask

    initial begin
        // Asynchronous reset assertion, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 8'h00);
        check("rst_r", remainder, 4'h0);
        check("rst_dbz", div_by_zero, 1'b0);

        // start held high during reset must be ignored.
        start    = 1'b1;
        dividend = 8'h96;
        divisor  = 4'hF;
        tick();
        tick();
        check("rst_ignore_busy", busy, 1'b0);
        check("rst_ignore_done", done, 1'b0);

        // Release with start still high: first edge accepts it.
        rst_n = 1'b1;
        run_div("d96_f", 8'h96, 4'hF, 8'h0A, 4'h0, 1'b0, 1'b1);

        // Return to IDLE: done drops, result holds.
        tick();
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_holdq", quotient, 8'h0A);

        // Back-to-back: second start issued in the done cycle.
        run_div("dff_7", 8'hFF, 4'h7, 8'h24, 4'h3, 1'b0, 1'b1);
        run_div("d0c_3", 8'h0C, 4'h3, 8'h04, 4'h0, 1'b0, 1'b1);
        tick();

        // Divide by zero from IDLE, then from DONE, then a normal one.
        run_div("d0a_0", 8'h0A, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b1);
        run_div("d05_0", 8'h05, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b1);
        run_div("d37_5", 8'h37, 4'h5, 8'h0B, 4'h0, 1'b0, 1'b1);
        tick();
        check("dz_idle_done", done, 1'b0);
        check("dz_idle_busy", busy, 1'b0);

        // Start during CALC is ignored.
        start    = 1'b1;
        dividend = 8'h64;
        divisor  = 4'h9;
        tick();                     // accept edge k
        start    = 1'b0;
        tick();                     // k+1
        tick();                     // k+2, inside CALC cycle 3
        start    = 1'b1;
        dividend = 8'h01;
        divisor  = 4'h1;
        tick();                     // k+3, start must be ignored
        start    = 1'b0;
        check("ign_busy", busy, 1'b1);
        check("ign_holdq", quotient, 8'h0B);
        for (int i = 0; i < 5; i++) tick();   // k+8
        check("ign_done", done, 1'b1);
        check("ign_q", quotient, 8'h0B);
        check("ign_r", remainder, 4'h1);
        check("ign_dbz", div_by_zero, 1'b0);
        tick();
        check("ign_after_done", done, 1'b0);

        // Reset in the middle of CALC.
        start    = 1'b1;
        dividend = 8'hC8;
        divisor  = 4'h6;
        tick();                     // k
        start    = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // k+4, CALC cycle 5
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_q", quotient, 8'h00);
        check("mid_rst_r", remainder, 4'h0);
        check("mid_rst_dbz", div_by_zero, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("mid_rst_no_done", done, 1'b0);
            tick();
        end
        hold_q = '0;
        hold_r = '0;
        hold_z = 1'b0;
        run_div("d0f_2", 8'h0F, 4'h2, 8'h07, 4'h1, 1'b0, 1'b1);

        // Sweep every pair, all issued back-to-back.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] eq;
                logic [3:0] er;
                if (b == 0) begin
                    eq = 8'hFF;
                    er = 4'h0;
                end else begin
                    eq = 8'(a / b);
                    er = 4'(a % b);
                end
                run_div("sweep", 8'(a), 4'(b), eq, er, (b == 0), 1'b0);
                if (b != 0) begin
                    check("sweep_ident", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                end
            end
        end
        tick();
        check("final_idle", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
